// File: rtl/jtpopeye_objdma.sv
// Vertical-blank object DMA: copies a frame's object table from CPU space
// into the object line buffer RAM while holding the CPU bus.
module jtpopeye_objdma #(
  parameter int AW      = 10,
  parameter int DMA_LEN = 512,
  parameter int TIMEOUT = 63
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pxl_cen,
  input  logic          VB,
  input  logic          dma_en,
  input  logic [15:0]   src_base,
  output logic          busrq,
  input  logic          busak,
  output logic [15:0]   cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic [AW-1:0] obj_addr,
  output logic [7:0]    obj_dout,
  output logic          obj_we,
  output logic          busy,
  output logic          done,
  output logic          abort
);

  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LEN      = CW'(DMA_LEN);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RD,
    WR,
    REL
  } state_t;

  state_t        st;
  logic          vb_l;
  logic          pend;
  logic          pend_en;
  logic [15:0]   pend_base;
  logic [15:0]   base;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tmo;
  logic [CW-1:0] cnt_nx;
  logic          vb_rise;

  assign cnt_nx  = cnt + 1'b1;
  assign vb_rise = VB & ~vb_l;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= IDLE;
      vb_l      <= 1'b0;
      pend      <= 1'b0;
      pend_en   <= 1'b0;
      pend_base <= '0;
      base      <= '0;
      cnt       <= '0;
      tmo       <= '0;
      busrq     <= 1'b0;
      cpu_addr  <= '0;
      obj_addr  <= '0;
      obj_dout  <= '0;
      obj_we    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      abort     <= 1'b0;
    end else begin
      done  <= 1'b0;
      abort <= 1'b0;
      vb_l  <= VB;
      // Edges seen while a transfer is active are dropped: one per frame
      if (st == IDLE && vb_rise) begin
        pend      <= 1'b1;
        pend_en   <= dma_en;
        pend_base <= src_base;
      end
      if (pxl_cen) begin
        case (st)
          IDLE: begin
            if (pend) begin
              pend <= 1'b0;
              if (pend_en) begin
                base  <= pend_base;
                cnt   <= '0;
                tmo   <= '0;
                busrq <= 1'b1;
                busy  <= 1'b1;
                st    <= REQ;
              end
            end
          end
          REQ: begin
            if (!VB || (!busak && tmo == TMO_LAST)) begin
              busrq <= 1'b0;
              abort <= 1'b1;
              st    <= REL;
            end else if (busak) begin
              cpu_addr <= base;
              st       <= RD;
            end else begin
              tmo <= tmo + 1'b1;
            end
          end
          RD: begin
            if (!VB) begin
              busrq <= 1'b0;
              abort <= 1'b1;
              st    <= REL;
            end else if (busak) begin
              obj_we   <= 1'b1;
              obj_dout <= cpu_din;
              obj_addr <= cnt[AW-1:0];
              st       <= WR;
            end
          end
          WR: begin
            obj_we <= 1'b0;
            if (!VB) begin
              busrq <= 1'b0;
              abort <= 1'b1;
              st    <= REL;
            end else if (busak) begin
              cnt <= cnt_nx;
              if (cnt_nx == LEN) begin
                busrq <= 1'b0;
                done  <= 1'b1;
                st    <= REL;
              end else begin
                cpu_addr <= base + 16'(cnt_nx);
                st       <= RD;
              end
            end
          end
          REL: begin
            if (!busak) begin
              busy <= 1'b0;
              st   <= IDLE;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtpopeye_objdma.sv
// Scoreboard bench for the object DMA: stimulus queues expected writes and
// completion events, a monitor pops and compares as the DUT produces them.
module tb_jtpopeye_objdma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pxl_cen = 1'b0;
  logic        VB = 1'b0;
  logic        dma_en = 1'b0;
  logic [15:0] src_base = '0;
  logic        busak = 1'b0;
  logic        busrq;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic [9:0]  obj_addr;
  logic [7:0]  obj_dout;
  logic        obj_we;
  logic        busy;
  logic        done;
  logic        abort;

  jtpopeye_objdma #(.AW(10), .DMA_LEN(512), .TIMEOUT(63)) dut (
    .clk      (clk),
    .rst      (rst),
    .pxl_cen  (pxl_cen),
    .VB       (VB),
    .dma_en   (dma_en),
    .src_base (src_base),
    .busrq    (busrq),
    .busak    (busak),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_din),
    .obj_addr (obj_addr),
    .obj_dout (obj_dout),
    .obj_we   (obj_we),
    .busy     (busy),
    .done     (done),
    .abort    (abort)
  );

  typedef struct {
    logic [15:0] a;
    logic [9:0]  o;
    logic [7:0]  d;
  } wr_t;

  wr_t wq[$];
  int  evq[$];
  int  checks = 0;
  int  errors = 0;
  int  nwr = 0;

  function automatic logic [7:0] fdat(logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  assign cpu_din = fdat(cpu_addr);

  always #5 clk = ~clk;
  always @(posedge clk) #2 pxl_cen = ~pxl_cen;

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic tick();
    do @(posedge clk); while (!pxl_cen);
    #1;
  endtask

  task automatic push_wr(logic [15:0] b, int n);
    wr_t e;
    for (int i = 0; i < n; i++) begin
      e.a = b + 16'(i);
      e.o = 10'(i);
      e.d = fdat(e.a);
      wq.push_back(e);
    end
  endtask

  task automatic wait_busrq(logic v, int budget, output int n);
    n = 0;
    while (busrq !== v && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_idle(string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic wait_nwr(string tag, int target);
    int n;
    n = 0;
    while (nwr < target && n < 20000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_reach"}, nwr >= target, 1);
  endtask

  task automatic run_full(string tag, logic [15:0] b, int gd);
    int n;
    push_wr(b, 512);
    evq.push_back(1);
    nwr = 0;
    dma_en = 1'b1;
    src_base = b;
    VB = 1'b1;
    wait_busrq(1'b1, 10, n);
    chk({tag, "_req"}, busrq, 1);
    repeat (gd) tick();
    busak = 1'b1;
    wait_busrq(1'b0, 1200, n);
    chk({tag, "_ticks"}, n, 1025);
    busak = 1'b0;
    wait_idle(tag);
    VB = 1'b0;
    repeat (2) tick();
    chk({tag, "_writes"}, nwr, 512);
    chk({tag, "_wq"}, wq.size(), 0);
    chk({tag, "_evq"}, evq.size(), 0);
  endtask

  // Monitor: pops expected writes and completion events
  initial begin
    wr_t e;
    int  k;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (pxl_cen && obj_we) begin
          nwr++;
          if (wq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_write: got obj_addr %0h expected none",
                     obj_addr);
          end else begin
            e = wq.pop_front();
            chk("wr_cpu_addr", cpu_addr, e.a);
            chk("wr_obj_addr", obj_addr, e.o);
            chk("wr_obj_dout", obj_dout, e.d);
          end
        end
        if (done || abort) begin
          chk("done_abort_excl", done & abort, 0);
          if (evq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_event: got done=%0b abort=%0b expected none",
                     done, abort);
          end else begin
            k = evq.pop_front();
            chk("event_kind", {abort, done}, k);
          end
        end
      end
    end
  end

  initial begin
    int n;
    int n0;
    logic [15:0] a0;
    logic seen;

    repeat (3) tick();
    chk("reset_outs",
        {busrq, cpu_addr, obj_addr, obj_dout, obj_we, busy, done, abort}, 0);
    rst = 1'b0;
    repeat (3) tick();

    // Normal transfer, grant 3 ticks after request
    run_full("t1", 16'h8000, 3);

    // Disabled frame
    dma_en = 1'b0;
    VB = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      tick();
      seen = seen | busrq | busy;
    end
    chk("t2_no_req", seen, 0);
    VB = 1'b0;
    repeat (2) tick();

    // Bus never granted
    dma_en = 1'b1;
    evq.push_back(2);
    VB = 1'b1;
    wait_busrq(1'b1, 10, n);
    chk("t3_req", busrq, 1);
    n = 0;
    while (busrq && n < 200) begin
      tick();
      n++;
    end
    chk("t3_busrq_ticks", n, 63);
    repeat (2) tick();
    chk("t3_busy", busy, 0);
    VB = 1'b0;
    repeat (2) tick();
    chk("t3_evq", evq.size(), 0);

    // VB falls after 100 bytes, then a full restart
    src_base = 16'h1234;
    push_wr(16'h1234, 100);
    evq.push_back(2);
    nwr = 0;
    VB = 1'b1;
    wait_busrq(1'b1, 10, n);
    tick();
    busak = 1'b1;
    wait_nwr("t4", 100);
    VB = 1'b0;
    wait_busrq(1'b0, 5, n);
    chk("t4_rq_low", busrq, 0);
    busak = 1'b0;
    wait_idle("t4");
    repeat (4) tick();
    chk("t4_writes", nwr, 100);
    chk("t4_wq", wq.size(), 0);
    chk("t4_evq", evq.size(), 0);
    run_full("t4r", 16'h0100, 1);

    // Grant withdrawn for 10 ticks, source wraps past FFFF
    src_base = 16'hFF00;
    push_wr(16'hFF00, 512);
    evq.push_back(1);
    nwr = 0;
    VB = 1'b1;
    wait_busrq(1'b1, 10, n);
    tick();
    busak = 1'b1;
    wait_nwr("t5", 200);
    busak = 1'b0;
    tick();
    n0 = nwr;
    a0 = cpu_addr;
    repeat (10) tick();
    chk("t5_hold_cnt", nwr, n0);
    chk("t5_hold_addr", cpu_addr, 16'hFFC7);
    chk("t5_hold_addr2", a0, 16'hFFC7);
    busak = 1'b1;
    wait_busrq(1'b0, 1200, n);
    chk("t5_rq_low", busrq, 0);
    busak = 1'b0;
    wait_idle("t5");
    VB = 1'b0;
    repeat (2) tick();
    chk("t5_writes", nwr, 512);
    chk("t5_wq", wq.size(), 0);
    chk("t5_evq", evq.size(), 0);

    // Reset in the middle of a write
    src_base = 16'h4000;
    push_wr(16'h4000, 512);
    nwr = 0;
    VB = 1'b1;
    wait_busrq(1'b1, 10, n);
    tick();
    busak = 1'b1;
    wait_nwr("t6", 50);
    chk("t6_we_before", obj_we, 1);
    rst = 1'b1;
    #1;
    chk("t6_reset_outs",
        {busrq, cpu_addr, obj_addr, obj_dout, obj_we, busy, done, abort}, 0);
    wq.delete();
    evq.delete();
    busak = 1'b0;
    VB = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();
    run_full("t6r", 16'h4000, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
